// File: rtl/motor_cmd_if.sv
// Command channel into the motor ramp controller: valid/ready handshake carrying
// a direction code and a target speed.
interface motor_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic [7:0] cmd_speed;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_speed,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Turns direction/speed commands into a ramped PWM duty plus bridge direction pins.
// Duty moves one bounded step per ramp tick; commands stall during decel/dead time.
module motor_ramp_ctrl #(
    parameter int unsigned DUTY_UNIT   = 3906,
    parameter int unsigned RAMP_TICK   = 50000,
    parameter int unsigned RAMP_STEP   = 3906,
    parameter int unsigned DEAD_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    motor_cmd_if.slave  cmd,
    output logic [19:0] duty,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        at_speed,
    output logic        busy
);

    localparam int TW = (RAMP_TICK   > 1) ? $clog2(RAMP_TICK)   : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [1:0] DIR_STOP  = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RAMP, S_RUN, S_DECEL, S_DEAD, S_BRAKE
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] duty_q, duty_d;
    logic [19:0] target_q, target_d;
    logic [1:0]  cur_dir_q, cur_dir_d;
    logic [9:0]  pend_q, pend_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] dead_q, dead_d;

    logic        tick_wrap;
    logic        accept;
    logic        ready;
    logic [1:0]  eff_dir;
    logic [19:0] cmd_target;
    logic [19:0] pend_target;
    logic [19:0] step;

    assign tick_wrap   = (tick_q == TW'(RAMP_TICK - 1));
    assign ready       = (state_q != S_DECEL) && (state_q != S_DEAD);
    assign accept      = cmd.cmd_valid && ready;
    assign cmd_target  = 20'(cmd.cmd_speed) * 20'(DUTY_UNIT);
    assign pend_target = 20'(pend_q[7:0]) * 20'(DUTY_UNIT);
    assign step        = 20'(RAMP_STEP);

    // A zero-speed drive command is just a stop request.
    always_comb begin
        eff_dir = cmd.cmd_dir;
        if (((cmd.cmd_dir == DIR_FWD) || (cmd.cmd_dir == DIR_REV)) && (cmd.cmd_speed == 8'd0)) begin
            eff_dir = DIR_STOP;
        end
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        cur_dir_d = cur_dir_q;
        pend_d    = pend_q;
        tick_d    = tick_wrap ? '0 : tick_q + TW'(1);
        dead_d    = '0;

        if (tick_wrap && ((state_q == S_RAMP) || (state_q == S_DECEL))) begin
            if (duty_q < target_q) begin
                duty_d = ((target_q - duty_q) > step) ? duty_q + step : target_q;
            end else if (duty_q > target_q) begin
                duty_d = ((duty_q - target_q) > step) ? duty_q - step : target_q;
            end
        end

        case (state_q)
            S_DECEL: begin
                if (duty_d == 20'd0) begin
                    state_d = S_DEAD;
                end
            end
            S_DEAD: begin
                if (dead_q == DW'(DEAD_CYCLES - 1)) begin
                    state_d   = S_RAMP;
                    cur_dir_d = pend_q[9:8];
                    target_d  = pend_target;
                    pend_d    = '0;
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            default: begin
                if (accept) begin
                    case (eff_dir)
                        DIR_BRAKE: begin
                            state_d   = S_BRAKE;
                            duty_d    = '0;
                            target_d  = '0;
                            cur_dir_d = DIR_STOP;
                        end
                        DIR_STOP: begin
                            target_d = '0;
                            state_d  = S_RAMP;
                        end
                        default: begin
                            if ((cur_dir_q == eff_dir) || (cur_dir_q == DIR_STOP)) begin
                                cur_dir_d = eff_dir;
                                target_d  = cmd_target;
                                state_d   = S_RAMP;
                            end else begin
                                pend_d   = {eff_dir, cmd.cmd_speed};
                                target_d = '0;
                                state_d  = S_DECEL;
                            end
                        end
                    endcase
                end
            end
        endcase

        // Settling: a ramp that lands on its target either runs or, at zero, stops.
        if ((state_d == S_RAMP) && (duty_d == target_d)) begin
            if (target_d != 20'd0) begin
                state_d = S_RUN;
            end else begin
                state_d   = S_IDLE;
                cur_dir_d = DIR_STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            duty_q    <= '0;
            target_q  <= '0;
            cur_dir_q <= DIR_STOP;
            pend_q    <= '0;
            tick_q    <= '0;
            dead_q    <= '0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            cur_dir_q <= cur_dir_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            dead_q    <= dead_d;
        end
    end

    always_comb begin
        {in1, in2, in3, in4} = 4'b0000;
        case (state_q)
            S_BRAKE: {in1, in2, in3, in4} = 4'b1111;
            S_IDLE, S_DEAD: {in1, in2, in3, in4} = 4'b0000;
            default: begin
                if (cur_dir_q == DIR_FWD) begin
                    {in1, in2, in3, in4} = 4'b1010;
                end else if (cur_dir_q == DIR_REV) begin
                    {in1, in2, in3, in4} = 4'b0101;
                end
            end
        endcase
    end

    assign duty          = duty_q;
    assign cmd.cmd_ready = ready;
    assign at_speed      = (state_q == S_RUN);
    assign busy          = (state_q != S_IDLE) && (state_q != S_RUN);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with short tick/dead parameters.
module tb_motor_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic [19:0] duty;
    logic        in1, in2, in3, in4;
    logic        at_speed;
    logic        busy;
    logic [3:0]  pins;

    int n_checks;
    int n_fail;

    motor_cmd_if cmd_if ();

    motor_ramp_ctrl #(
        .DUTY_UNIT  (3906),
        .RAMP_TICK  (4),
        .RAMP_STEP  (1000),
        .DEAD_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if),
        .duty    (duty),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .in4     (in4),
        .at_speed(at_speed),
        .busy    (busy)
    );

    assign pins = {in1, in2, in3, in4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Presents a command and holds it until the handshake edge.
    task automatic send(input logic [1:0] d, input logic [7:0] s);
        int n;
        n = 0;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_speed = s;
        cmd_if.cmd_valid = 1'b1;
        while (!cmd_if.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: got %b want 1", cmd_if.cmd_ready);
        end
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_change(input logic [19:0] prev, output logic [19:0] val, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (duty == prev && cyc < 60);
        val = duty;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 2'b00;
        cmd_if.cmd_speed = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (duty !== 20'd0) begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty); end
        n_checks++; if (pins !== 4'b0000) begin n_fail++; $display("FAIL reset_pins: got %b want 0000", pins); end
        n_checks++; if (at_speed !== 1'b0) begin n_fail++; $display("FAIL reset_at_speed: got %b want 0", at_speed); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_ramp_up;
        logic [19:0] exp_v [4];
        logic [19:0] prev, v;
        int c;
        exp_v = '{20'd1000, 20'd2000, 20'd3000, 20'd3906};
        send(2'b01, 8'd1);
        n_checks++; if (pins !== 4'b1010) begin n_fail++; $display("FAIL up_pins: got %b want 1010", pins); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy: got %b want 1", busy); end
        prev = 20'd0;
        for (int i = 0; i < 4; i++) begin
            wait_change(prev, v, c);
            n_checks++; if (v !== exp_v[i]) begin n_fail++; $display("FAIL up_duty[%0d]: got %0d want %0d", i, v, exp_v[i]); end
            if (i > 0) begin
                n_checks++; if (c !== 4) begin n_fail++; $display("FAIL up_interval[%0d]: got %0d want 4", i, c); end
            end
            prev = v;
        end
        n_checks++; if (at_speed !== 1'b1) begin n_fail++; $display("FAIL up_at_speed: got %b want 1", at_speed); end
        repeat (10) @(negedge clk);
        n_checks++; if (duty !== 20'd3906) begin n_fail++; $display("FAIL up_hold_duty: got %0d want 3906", duty); end
        n_checks++; if (at_speed !== 1'b1) begin n_fail++; $display("FAIL up_hold_at_speed: got %b want 1", at_speed); end
    endtask

    task automatic test_reverse;
        logic [19:0] dn [4];
        logic [19:0] up [4];
        logic [19:0] prev, v;
        int c, cnt;
        dn = '{20'd2906, 20'd1906, 20'd906, 20'd0};
        up = '{20'd1000, 20'd2000, 20'd3000, 20'd3906};
        send(2'b10, 8'd1);
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rev_ready: got %b want 0", cmd_if.cmd_ready); end
        n_checks++; if (pins !== 4'b1010) begin n_fail++; $display("FAIL rev_decel_pins: got %b want 1010", pins); end
        prev = 20'd3906;
        for (int i = 0; i < 4; i++) begin
            wait_change(prev, v, c);
            n_checks++; if (v !== dn[i]) begin n_fail++; $display("FAIL rev_down[%0d]: got %0d want %0d", i, v, dn[i]); end
            prev = v;
        end
        n_checks++; if (pins !== 4'b0000) begin n_fail++; $display("FAIL rev_dead_pins: got %b want 0000", pins); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rev_dead_ready: got %b want 0", cmd_if.cmd_ready); end
        cnt = 1;
        forever begin
            @(negedge clk);
            if (pins != 4'b0000 || cnt > 40) break;
            cnt++;
        end
        n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL rev_dead_len: got %0d want 8", cnt); end
        n_checks++; if (pins !== 4'b0101) begin n_fail++; $display("FAIL rev_pins: got %b want 0101", pins); end
        prev = 20'd0;
        for (int i = 0; i < 4; i++) begin
            wait_change(prev, v, c);
            n_checks++; if (v !== up[i]) begin n_fail++; $display("FAIL rev_up[%0d]: got %0d want %0d", i, v, up[i]); end
            prev = v;
        end
        n_checks++; if (at_speed !== 1'b1) begin n_fail++; $display("FAIL rev_at_speed: got %b want 1", at_speed); end
    endtask

    task automatic test_held_during_decel;
        int blocked, n;
        send(2'b01, 8'd1);
        cmd_if.cmd_dir   = 2'b01;
        cmd_if.cmd_speed = 8'd2;
        cmd_if.cmd_valid = 1'b1;
        blocked = 0;
        forever begin
            @(negedge clk);
            if (cmd_if.cmd_ready || blocked > 100) break;
            blocked++;
        end
        n_checks++; if (blocked < 21 || blocked > 24) begin n_fail++; $display("FAIL held_blocked: got %0d want 21..24", blocked); end
        n_checks++; if (pins !== 4'b1010) begin n_fail++; $display("FAIL held_pins: got %b want 1010", pins); end
        n_checks++; if (duty !== 20'd0) begin n_fail++; $display("FAIL held_duty0: got %0d want 0", duty); end
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        n = 0;
        while (!at_speed && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (duty !== 20'd7812) begin n_fail++; $display("FAIL held_final_duty: got %0d want 7812", duty); end
    endtask

    task automatic test_brake;
        logic [19:0] v;
        int c, n;
        send(2'b11, 8'd0);
        n_checks++; if (duty !== 20'd0) begin n_fail++; $display("FAIL brake_duty: got %0d want 0", duty); end
        n_checks++; if (pins !== 4'b1111) begin n_fail++; $display("FAIL brake_pins: got %b want 1111", pins); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL brake_ready: got %b want 1", cmd_if.cmd_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL brake_busy: got %b want 1", busy); end
        repeat (6) @(negedge clk);
        n_checks++; if (pins !== 4'b1111) begin n_fail++; $display("FAIL brake_hold_pins: got %b want 1111", pins); end
        send(2'b01, 8'd1);
        n_checks++; if (pins !== 4'b1010) begin n_fail++; $display("FAIL brake_fwd_pins: got %b want 1010", pins); end
        wait_change(20'd0, v, c);
        n_checks++; if (v !== 20'd1000) begin n_fail++; $display("FAIL brake_first_step: got %0d want 1000", v); end
        n = 0;
        while (!at_speed && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (duty !== 20'd3906) begin n_fail++; $display("FAIL brake_final_duty: got %0d want 3906", duty); end
    endtask

    task automatic test_stop_and_zero;
        logic [19:0] dn [4];
        logic [19:0] prev, v;
        int c;
        dn = '{20'd2906, 20'd1906, 20'd906, 20'd0};
        send(2'b00, 8'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_busy: got %b want 1", busy); end
        prev = 20'd3906;
        for (int i = 0; i < 4; i++) begin
            wait_change(prev, v, c);
            n_checks++; if (v !== dn[i]) begin n_fail++; $display("FAIL stop_down[%0d]: got %0d want %0d", i, v, dn[i]); end
            prev = v;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle_busy: got %b want 0", busy); end
        n_checks++; if (pins !== 4'b0000) begin n_fail++; $display("FAIL stop_idle_pins: got %b want 0000", pins); end
        send(2'b01, 8'd0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
        n_checks++; if (pins !== 4'b0000) begin n_fail++; $display("FAIL zero_pins: got %b want 0000", pins); end
        repeat (10) @(negedge clk);
        n_checks++; if (duty !== 20'd0) begin n_fail++; $display("FAIL zero_duty: got %0d want 0", duty); end
        n_checks++; if (at_speed !== 1'b0) begin n_fail++; $display("FAIL zero_at_speed: got %b want 0", at_speed); end
    endtask

    task automatic test_retarget;
        logic [19:0] v;
        int c;
        send(2'b01, 8'd2);
        wait_change(20'd0, v, c);
        n_checks++; if (v !== 20'd1000) begin n_fail++; $display("FAIL retgt_first: got %0d want 1000", v); end
        send(2'b01, 8'd1);
        wait_change(20'd1000, v, c);
        n_checks++; if (v !== 20'd2000) begin n_fail++; $display("FAIL retgt_second: got %0d want 2000", v); end
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL retgt_interval: got %0d want 4", c); end
        wait_change(20'd2000, v, c);
        wait_change(20'd3000, v, c);
        n_checks++; if (v !== 20'd3906) begin n_fail++; $display("FAIL retgt_final: got %0d want 3906", v); end
        n_checks++; if (at_speed !== 1'b1) begin n_fail++; $display("FAIL retgt_at_speed: got %b want 1", at_speed); end
    endtask

    task automatic test_reset_in_dead;
        int n;
        send(2'b10, 8'd1);
        n = 0;
        while (duty != 20'd0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rdead_pre_busy: got %b want 1", busy); end
        rst = 1'b1;
        cmd_if.cmd_dir   = 2'b01;
        cmd_if.cmd_speed = 8'd1;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (duty !== 20'd0) begin n_fail++; $display("FAIL rdead_duty: got %0d want 0", duty); end
        n_checks++; if (pins !== 4'b0000) begin n_fail++; $display("FAIL rdead_pins: got %b want 0000", pins); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rdead_busy: got %b want 0", busy); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rdead_ready: got %b want 1", cmd_if.cmd_ready); end
        repeat (30) @(negedge clk);
        n_checks++; if (pins !== 4'b0000) begin n_fail++; $display("FAIL rdead_late_pins: got %b want 0000", pins); end
        n_checks++; if (duty !== 20'd0) begin n_fail++; $display("FAIL rdead_late_duty: got %0d want 0", duty); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 2'b00;
        cmd_if.cmd_speed = 8'd0;
        test_reset;
        test_ramp_up;
        test_reverse;
        test_held_during_decel;
        test_brake;
        test_stop_and_zero;
        test_retarget;
        test_reset_in_dead;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Upstream command stage for the motor PWM enable generator: turns direction/speed commands into a ramped duty (high-time, in clk cycles) plus L298-style direction pins.

Interface
REQ-001 Parameter DUTY_UNIT, default 3906, clk cycles of duty per speed LSB (255*3906 = 996030 < 20 ms period).
REQ-002 Parameter RAMP_TICK, default 50000, clk cycles between ramp steps.
REQ-003 Parameter RAMP_STEP, default 3906, maximum duty change per ramp step.
REQ-004 Parameter DEAD_CYCLES, default 500000, all-pins-low dead time before a direction reversal.
REQ-005 clk  in  1  system clock; all logic on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready on a clk edge.
REQ-009 cmd_dir  in  2  00 STOP, 01 FWD, 10 REV, 11 BRAKE.
REQ-010 cmd_speed  in  8  target speed, 0..255.
REQ-011 duty  out  20  current high-time per period, in clk cycles, for the PWM stage.
REQ-012 in1, in2, in3, in4  out  1 each  bridge direction pins, both channels.
REQ-013 at_speed  out  1  high while state is RUN.
REQ-014 busy  out  1  high in any state other than IDLE and RUN.

Function
REQ-015 States SHALL be IDLE, RAMP, RUN, DECEL, DEAD and BRAKE; state, duty, target, cur_dir and pend are registered.
REQ-016 Pins SHALL be FWD 1010, REV 0101, STOP/DEAD 0000 and BRAKE 1111 (order in1..in4), all decoded from cur_dir and state.
REQ-017 cmd_ready SHALL be 1 in IDLE, RAMP, RUN and BRAKE, and 0 in DECEL and DEAD.
REQ-018 A ramp tick counter SHALL count 0..RAMP_TICK-1 and wrap; duty changes only on the cycle the counter wraps.
REQ-019 On a tick, duty SHALL move toward target by min(RAMP_STEP, |target-duty|), with no overshoot and no wrap.
REQ-020 target SHALL equal cmd_speed*DUTY_UNIT, computed at 20-bit width without truncation.
REQ-021 Accepted FWD/REV with cur_dir equal to the command or STOP SHALL set cur_dir and target, then go to RAMP, or to RUN if duty already equals target.
REQ-022 Accepted FWD/REV opposite to cur_dir SHALL latch pend={dir,speed}, set target=0 and enter DECEL.
REQ-023 DECEL SHALL ramp duty down; when duty==0 it SHALL enter DEAD, with pins 0000 for exactly DEAD_CYCLES cycles.
REQ-024 On DEAD exit, cur_dir and target SHALL load from pend and the state SHALL go to RAMP.
REQ-025 Accepted STOP SHALL set target=0, RAMP down, and on reaching duty==0 set cur_dir=STOP and enter IDLE.
REQ-026 Accepted BRAKE from any ready state SHALL force duty=0 and pins 1111 on the next edge, bypassing the ramp.
REQ-027 BRAKE SHALL be held until the next accepted command, which is then processed as from cur_dir=STOP.
REQ-028 FWD/REV with speed 0 SHALL be treated as STOP.
REQ-029 A new same-direction command during RAMP/RUN SHALL retarget immediately without resetting the tick counter.
REQ-030 RAMP SHALL enter RUN on the edge where duty==target!=0.

Reset
REQ-031 rst SHALL force state=IDLE, duty=0, target=0, cur_dir=STOP, pend=0, tick and dead counters=0, pins 0000, at_speed=0, busy=0, cmd_ready=1.
REQ-032 rst asserted mid-ramp or mid-DEAD SHALL abandon the operation with no pending command retained; rst has priority over cmd_valid.

Verification (RAMP_TICK=4, RAMP_STEP=1000, DUTY_UNIT=3906, DEAD_CYCLES=8)
REQ-033 Reset, then FWD speed 1 -> pins 1010, then duty 1000, 2000, 3000, 3906 on successive ticks, then at_speed=1 and duty stays 3906.
REQ-034 RUN FWD speed 1, then REV speed 1 -> cmd_ready=0, duty ramps down to 0, pins 0000 for 8 cycles, then pins 0101 and duty ramps to 3906.
REQ-035 RUN FWD speed 2 (duty 7812), then BRAKE -> next edge duty=0, pins 1111, cmd_ready=1; a following FWD speed 1 ramps up from 0.
REQ-036 FWD speed 0 from IDLE -> state stays IDLE, pins 0000, duty 0.
REQ-037 rst pulsed during DEAD -> next edge duty=0, pins 0000, IDLE, and the pending REV is never applied.
REQ-038 cmd_valid held during DECEL -> not accepted until DEAD completes, then accepted in the first cycle cmd_ready=1.
